// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  // Default operand/result width.
  localparam int unsigned WidthDefault = 4;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational borrow cell.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB first,
// with registered diff/borrow/busy/done outputs.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state logic for the controller, datapath shifters and registered outputs.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        // New bit enters at the MSB so bit i lands at position i after WIDTH shifts.
        res_d  = {fs_d, res_q[WIDTH-1:1]};
        bin_d  = fs_bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          diff_d   = {fs_d, res_q[WIDTH-1:1]};
          borrow_d = fs_bout;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // Single state register bank; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;
  logic         done;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bw;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int unsigned chk_cnt;
  int unsigned pass_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("diff", diff, e.d);
        check("borrow", borrow, e.bw);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one start pulse; expectation recorded right after the accepting edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    e.d   = ed;
    e.bw  = eb;
    e.cyc = cyc + W;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = ~av;  // in-flight operation must not see this
    b     = ~bv;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb);
    issue(av, bv, ed, eb);
    wait_idle();
  endtask

  logic [W-1:0] va[3] = '{4'd3, 4'd4, 4'd0};
  logic [W-1:0] vb[3] = '{4'd1, 4'd15, 4'd1};
  logic [W-1:0] vd[3] = '{4'd2, 4'd5, 4'd15};
  logic         vw[3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    chk_cnt  = 0;
    pass_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    #12;
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // First start after reset release, equal operands.
    run_op(4'd4, 4'd4, 4'd0, 1'b0);

    for (int i = 0; i < 3; i++) run_op(va[i], vb[i], vd[i], vw[i]);

    // Start pulsed during RUN is ignored; busy covers RUN (4) + DONE (1).
    @(negedge clk);
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd3;
    @(posedge clk);
    #1;
    e.d   = 4'd4;
    e.bw  = 1'b0;
    e.cyc = cyc + W;
    sb_q.push_back(e);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy_window", busy, (i < 5) ? 1 : 0);
      if (i == 1) begin
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd2;
      end
      if (i == 2) start = 1'b0;
    end
    wait_idle();

    // Reset on the second RUN cycle aborts with no done pulse.
    @(negedge clk);
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(4'd15, 4'd4, 4'd11, 1'b0);

    // Start held high: three back-to-back operations, done every W+2 clocks.
    @(negedge clk);
    start = 1'b1;
    a     = 4'd10;
    b     = 4'd3;
    @(posedge clk);
    #1;
    e.d = 4'd7;  e.bw = 1'b0; e.cyc = cyc + W; sb_q.push_back(e);
    a = 4'd2;
    b = 4'd9;
    repeat (W + 2) @(posedge clk);
    #1;
    e.d = 4'd9;  e.bw = 1'b1; e.cyc = cyc + W; sb_q.push_back(e);
    a = 4'd8;
    b = 4'd8;
    repeat (W + 2) @(posedge clk);
    #1;
    e.d = 4'd0;  e.bw = 1'b0; e.cyc = cyc + W; sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Exhaustive sweep against (a - b) mod 16 and a < b.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        logic [W-1:0] xa, yb, rd;
        xa = W'(x);
        yb = W'(y);
        rd = xa - yb;
        run_op(xa, yb, rd, (x < y) ? 1'b1 : 1'b0);
      end
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
